// File: rtl/sa_seq_ctrl_if.sv
// Host-side command and slice-stream channels of the systolic job sequencer.
interface sa_seq_ctrl_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_len;
  logic            src_valid;
  logic            src_ready;
  logic [N*DW-1:0] src_a;
  logic [N*DW-1:0] src_b;

  modport master (
    output cmd_valid, cmd_len, src_valid, src_a, src_b,
    input  cmd_ready, src_ready
  );

  modport slave (
    input  cmd_valid, cmd_len, src_valid, src_a, src_b,
    output cmd_ready, src_ready
  );
endinterface

// File: rtl/sa_seq_ctrl.sv
// Job sequencer for one N x N systolic PE array: takes a K-length matmul command,
// pulses start, streams K A/B slice beats into the edge FIFOs, then waits for the
// corner PE result strobe under a watchdog and reports done/err/saturation.
module sa_seq_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  sa_seq_ctrl_if.slave    bus,
  output logic [N*DW-1:0] a_in,
  output logic [N*DW-1:0] b_in,
  output logic [N-1:0]    awe,
  output logic [N-1:0]    bwe,
  input  logic [N-1:0]    aff,
  input  logic [N-1:0]    bff,
  output logic            start,
  output logic [7:0]      max_cntr,
  output logic            hold,
  input  logic            res_ready,
  input  logic            se_last,
  input  logic            sat_in,
  output logic            done,
  output logic            err,
  output logic            sat_flag,
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StStart, StFeed, StWait, StDone} state_e;

  // Last watchdog value before expiry; the err pulse lands TMO cycles after WAIT entry.
  localparam logic [15:0] TmoLast = 16'(TMO - 1);

  state_e          state_q, state_d;
  logic            cmd_ready_q, busy_q, start_q, done_q, err_q, hold_q, sat_flag_q;
  logic [7:0]      max_cntr_q, beat_q;
  logic [15:0]     wdog_q;
  logic [N-1:0]    awe_q, bwe_q;
  logic [N*DW-1:0] a_in_q, b_in_q;
  logic            src_ready_c, cmd_fire, src_fire, timeout;

  assign src_ready_c   = (state_q == StFeed) & ~(|aff) & ~(|bff) & ~hold_q;
  assign cmd_fire      = bus.cmd_valid & cmd_ready_q;
  assign src_fire      = bus.src_valid & src_ready_c;
  // se_last has priority over an expiring watchdog.
  assign timeout       = (state_q == StWait) & ~se_last & ~hold_q & (wdog_q == TmoLast);
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.src_ready = src_ready_c;

  assign a_in     = a_in_q;
  assign b_in     = b_in_q;
  assign awe      = awe_q;
  assign bwe      = bwe_q;
  assign start    = start_q;
  assign max_cntr = max_cntr_q;
  assign hold     = hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign sat_flag = sat_flag_q;
  assign busy     = busy_q;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_fire && bus.cmd_len != 8'd0) state_d = StStart;
      StStart: state_d = StFeed;
      StFeed:  if (src_fire && beat_q == max_cntr_q) state_d = StWait;
      StWait: begin
        if (se_last)      state_d = StDone;
        else if (timeout) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= 1'b0;
      sat_flag_q  <= 1'b0;
      max_cntr_q  <= '0;
      beat_q      <= '0;
      wdog_q      <= '0;
      awe_q       <= '0;
      bwe_q       <= '0;
      a_in_q      <= '0;
      b_in_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      start_q     <= (state_d == StStart);
      done_q      <= (state_d == StDone);
      err_q       <= (cmd_fire && bus.cmd_len == 8'd0) || timeout;
      hold_q      <= ~res_ready & ((state_d == StFeed) | (state_d == StWait));
      awe_q       <= {N{src_fire}};
      bwe_q       <= {N{src_fire}};

      if (src_fire) begin
        a_in_q <= bus.src_a;
        b_in_q <= bus.src_b;
      end

      // No beat can be accepted in START, so the clear never collides with an increment.
      if (state_q == StStart)  beat_q <= '0;
      else if (src_fire)       beat_q <= beat_q + 8'd1;

      if (state_q != StWait)   wdog_q <= '0;
      else if (!hold_q)        wdog_q <= wdog_q + 16'd1;

      if (cmd_fire && bus.cmd_len != 8'd0) begin
        max_cntr_q <= bus.cmd_len - 8'd1;
        sat_flag_q <= 1'b0;
      end else if (sat_in && (state_q == StStart || state_q == StFeed || state_q == StWait)) begin
        sat_flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with a beat scoreboard on the FIFO write side.
module tb_sa_seq_ctrl;
  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] a_in, b_in;
  logic [N-1:0]    awe, bwe, aff, bff;
  logic            start, hold, res_ready, se_last, sat_in, done, err, sat_flag, busy;
  logic [7:0]      max_cntr;

  int    npass  = 0;
  int    ntot   = 0;
  int    nfail  = 0;
  int    wr_cnt = 0;
  beat_t sb_q[$];

  sa_seq_ctrl_if #(.N(N), .DW(DW)) bus ();

  sa_seq_ctrl #(.N(N), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .a_in(a_in), .b_in(b_in), .awe(awe), .bwe(bwe), .aff(aff), .bff(bff),
    .start(start), .max_cntr(max_cntr), .hold(hold), .res_ready(res_ready),
    .se_last(se_last), .sat_in(sat_in), .done(done), .err(err),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Offer fresh random beats until n are accepted or the cycle budget runs out.
  task automatic feed(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 50) begin
      bus.src_valid = 1'b1;
      bus.src_a     = {$urandom, $urandom};
      bus.src_b     = {$urandom, $urandom};
      #1;
      if (bus.src_ready) got++;
      nxt();
      cyc++;
    end
    bus.src_valid = 1'b0;
    chk("feed_beats", 64'(got), 64'(n));
  endtask

  task automatic issue(input logic [7:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    nxt();
    bus.cmd_valid = 1'b0;
  endtask

  // Scoreboard: accepted beats are pushed, each FIFO write pops and compares.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (awe !== '0 || bwe !== '0) begin
        beat_t e;
        wr_cnt++;
        chk("we_all_lanes", {56'd0, awe, bwe}, 64'hFF);
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("a_in", a_in, e.a);
          chk("b_in", b_in, e.b);
        end
      end
      if (bus.src_valid && bus.src_ready) sb_q.push_back('{a: bus.src_a, b: bus.src_b});
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = 8'd0;
    bus.src_valid = 1'b0; bus.src_a = '0; bus.src_b = '0;
    aff = '0; bff = '0; res_ready = 1'b1; se_last = 1'b0; sat_in = 1'b0;

    // Reset values
    nxt(); nxt();
    chk("rst_outs", {start, done, err, hold, sat_flag, busy, bus.cmd_ready, bus.src_ready}, 0);
    chk("rst_awe", {awe, bwe}, 0);
    chk("rst_max", max_cntr, 0);
    rst_n = 1'b1;
    nxt();
    chk("cmd_ready_idle", bus.cmd_ready, 1);

    // Basic job, K=3; a second command during START must be ignored
    wr_cnt = 0;
    issue(8'd3);
    chk("b_start", start, 1);
    chk("b_max", max_cntr, 2);
    chk("b_busy", {busy, bus.cmd_ready}, 2'b10);
    chk("b_srdy_start", bus.src_ready, 0);
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd7;
    nxt();
    bus.cmd_valid = 1'b0;
    chk("b_start_1cyc", start, 0);
    chk("b_max_hold", max_cntr, 2);
    feed(3);
    chk("b_no_done", done, 0);
    se_last = 1'b1;
    nxt();
    se_last = 1'b0;
    chk("b_done", {done, err}, 2'b10);
    chk("b_writes", 64'(wr_cnt), 3);
    nxt();
    chk("b_idle", {done, busy, bus.cmd_ready}, 3'b001);

    // Backpressure, K=4: aff[2] high for 5 cycles mid-FEED
    wr_cnt = 0;
    issue(8'd4);
    nxt();
    feed(1);
    aff = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      bus.src_valid = 1'b1;
      bus.src_a = {$urandom, $urandom};
      #1;
      chk("bp_srdy_low", bus.src_ready, 0);
      nxt();
    end
    aff = '0;
    feed(3);
    se_last = 1'b1;
    nxt();
    se_last = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_writes", 64'(wr_cnt), 4);
    nxt();

    // Freeze in WAIT with K=1: 5 counted + 10 frozen + 6 counted cycles stays below TMO
    issue(8'd1);
    nxt();
    feed(1);
    for (int i = 0; i < 4; i++) nxt();
    res_ready = 1'b0;
    #1;
    chk("fz_hold_lag", hold, 0);
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("fz_hold", {hold, err}, 2'b10);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      chk("fz_no_err", {err, done}, 0);
    end
    chk("fz_unhold", hold, 0);
    se_last = 1'b1;
    nxt();
    se_last = 1'b0;
    chk("fz_done", {done, err}, 2'b10);
    nxt();

    // Timeout, K=2: err exactly TMO cycles after WAIT entry
    issue(8'd2);
    nxt();
    feed(2);
    for (int i = 0; i < TMO; i++) begin
      chk("to_early", {err, done}, 0);
      nxt();
    end
    chk("to_err", {err, done, busy, bus.cmd_ready}, 4'b1001);
    nxt();
    chk("to_err_1cyc", err, 0);

    // se_last on the last watchdog cycle wins
    issue(8'd1);
    nxt();
    feed(1);
    for (int i = 0; i < TMO - 1; i++) nxt();
    se_last = 1'b1;
    nxt();
    se_last = 1'b0;
    chk("race_done", {done, err}, 2'b10);
    nxt();

    // Illegal length, then K=2 with one sat_in pulse in FEED
    issue(8'd0);
    chk("il_err", {err, start, busy, bus.cmd_ready}, 4'b1001);
    nxt();
    chk("il_err_1cyc", {err, start}, 0);
    issue(8'd2);
    nxt();
    sat_in = 1'b1;
    nxt();
    sat_in = 1'b0;
    chk("sat_set", sat_flag, 1);
    feed(2);
    se_last = 1'b1;
    nxt();
    se_last = 1'b0;
    chk("sat_at_done", {done, sat_flag}, 2'b11);
    nxt();
    chk("sat_sticky", sat_flag, 1);

    // Next accept clears sat_flag; async reset after 1 of 3 beats
    issue(8'd3);
    chk("sat_clear", sat_flag, 0);
    nxt();
    feed(1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_outs", {start, done, err, hold, sat_flag, busy, bus.cmd_ready, bus.src_ready}, 0);
    chk("rr_data", {awe, bwe, max_cntr}, 0);
    chk("rr_a_in", a_in, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    nxt();
    chk("rr_ready", {busy, bus.cmd_ready}, 2'b01);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
